// File: rtl/sweep_frame_packer_if.sv
// Stream interface from the frame packer to the host-link/serializer stage.
// The master drives data, valid and last. The slave drives ready.
interface sweep_frame_packer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] m_data;
   logic             m_valid;
   logic             m_last;
   logic             m_ready;

   modport master (
      output m_data,
      output m_valid,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_data,
      input  m_valid,
      input  m_last,
      output m_ready
   );
endinterface

// File: rtl/sweep_frame_packer.sv
// sweep_frame_packer: waits until the sample FIFO holds one block of
// READ_SCALAR samples, then pops the block with a single wide read.
// It sends the block as a frame: header, sequence number, the samples
// with sample 0 first, and a checksum beat that carries m_last.
// The checksum is (seq + sum of samples) mod 2^WIDTH.
// All stream outputs come straight from registers. The next-state logic
// computes what the stream will present in the next cycle.
module sweep_frame_packer #(
   parameter int               WIDTH       = 8,
   parameter int               READ_SCALAR = 10,
   parameter int               COUNT_W     = 5,
   parameter logic [WIDTH-1:0] HEADER      = 8'hA5
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [COUNT_W-1:0]             fifo_count,
   input  logic [WIDTH*READ_SCALAR-1:0]   fifo_dout,
   output logic                           fifo_rd_en,
   sweep_frame_packer_if.master           stream,
   output logic                           busy,
   output logic [15:0]                    frame_count
);

   localparam int IDX_W = (READ_SCALAR > 1) ? $clog2(READ_SCALAR) : 1;
   localparam int BUF_W = WIDTH * READ_SCALAR;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(READ_SCALAR - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LOAD  = 3'd2,
      ST_HDR   = 3'd3,
      ST_SEQ   = 3'd4,
      ST_DATA  = 3'd5,
      ST_CSUM  = 3'd6
   } state_t;

   // Modular checksum accumulation step.
   function automatic logic [WIDTH-1:0] csum_add(
      input logic [WIDTH-1:0] acc,
      input logic [WIDTH-1:0] sample
   );
      return acc + sample;
   endfunction

   state_t             state_r,   state_nxt_s;
   logic [WIDTH-1:0]   seq_r,     seq_nxt_s;
   logic [15:0]        fcount_r,  fcount_nxt_s;
   logic [WIDTH-1:0]   acc_r,     acc_nxt_s;
   logic [IDX_W-1:0]   idx_r,     idx_nxt_s;
   logic [BUF_W-1:0]   buf_r,     buf_nxt_s;
   logic [WIDTH-1:0]   m_data_r,  m_data_nxt_s;
   logic               m_valid_r, m_valid_nxt_s;
   logic               m_last_r,  m_last_nxt_s;
   logic               rd_en_r,   rd_en_nxt_s;
   logic               busy_r,    busy_nxt_s;
   logic               hs_s;

   // A beat transfers when the registered valid meets downstream ready.
   assign hs_s = m_valid_r & stream.m_ready;

   assign stream.m_data  = m_data_r;
   assign stream.m_valid = m_valid_r;
   assign stream.m_last  = m_last_r;
   assign fifo_rd_en     = rd_en_r;
   assign busy           = busy_r;
   assign frame_count    = fcount_r;

   // Next-state, next-output and datapath update logic.
   // The sample buffer shifts down one sample per DATA beat, so the next
   // sample is always in the lowest slice.
   always_comb begin
      state_nxt_s   = state_r;
      seq_nxt_s     = seq_r;
      fcount_nxt_s  = fcount_r;
      acc_nxt_s     = acc_r;
      idx_nxt_s     = idx_r;
      buf_nxt_s     = buf_r;
      m_data_nxt_s  = m_data_r;
      m_valid_nxt_s = m_valid_r;
      m_last_nxt_s  = m_last_r;
      rd_en_nxt_s   = 1'b0;

      case (state_r)
         ST_IDLE: begin
            if (enable && (fifo_count >= COUNT_W'(READ_SCALAR))) begin
               state_nxt_s = ST_FETCH;
               rd_en_nxt_s = 1'b1;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            state_nxt_s = ST_LOAD;
         end
         ST_LOAD: begin
            buf_nxt_s     = fifo_dout;
            m_data_nxt_s  = HEADER;
            m_valid_nxt_s = 1'b1;
            m_last_nxt_s  = 1'b0;
            state_nxt_s   = ST_HDR;
         end
         ST_HDR: begin
            if (hs_s) begin
               m_data_nxt_s = seq_r;
               state_nxt_s  = ST_SEQ;
            end else begin
               state_nxt_s  = ST_HDR;
            end
         end
         ST_SEQ: begin
            if (hs_s) begin
               acc_nxt_s    = seq_r;
               idx_nxt_s    = IDX_W'(0);
               m_data_nxt_s = buf_r[WIDTH-1:0];
               buf_nxt_s    = buf_r >> WIDTH;
               state_nxt_s  = ST_DATA;
            end else begin
               state_nxt_s  = ST_SEQ;
            end
         end
         ST_DATA: begin
            if (hs_s) begin
               acc_nxt_s = csum_add(acc_r, m_data_r);
               if (idx_r == LAST_IDX) begin
                  m_data_nxt_s = csum_add(acc_r, m_data_r);
                  m_last_nxt_s = 1'b1;
                  state_nxt_s  = ST_CSUM;
               end else begin
                  m_data_nxt_s = buf_r[WIDTH-1:0];
                  buf_nxt_s    = buf_r >> WIDTH;
                  idx_nxt_s    = idx_r + IDX_W'(1);
                  state_nxt_s  = ST_DATA;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_CSUM: begin
            if (hs_s) begin
               m_valid_nxt_s = 1'b0;
               m_last_nxt_s  = 1'b0;
               seq_nxt_s     = seq_r + WIDTH'(1);
               fcount_nxt_s  = fcount_r + 16'd1;
               state_nxt_s   = ST_IDLE;
            end else begin
               state_nxt_s   = ST_CSUM;
            end
         end
         default: begin
            m_valid_nxt_s = 1'b0;
            m_last_nxt_s  = 1'b0;
            state_nxt_s   = ST_IDLE;
         end
      endcase

      busy_nxt_s = (state_nxt_s != ST_IDLE);
   end

   // State, datapath and registered outputs, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         seq_r     <= WIDTH'(0);
         fcount_r  <= 16'd0;
         acc_r     <= WIDTH'(0);
         idx_r     <= IDX_W'(0);
         buf_r     <= BUF_W'(0);
         m_data_r  <= WIDTH'(0);
         m_valid_r <= 1'b0;
         m_last_r  <= 1'b0;
         rd_en_r   <= 1'b0;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         seq_r     <= seq_nxt_s;
         fcount_r  <= fcount_nxt_s;
         acc_r     <= acc_nxt_s;
         idx_r     <= idx_nxt_s;
         buf_r     <= buf_nxt_s;
         m_data_r  <= m_data_nxt_s;
         m_valid_r <= m_valid_nxt_s;
         m_last_r  <= m_last_nxt_s;
         rd_en_r   <= rd_en_nxt_s;
         busy_r    <= busy_nxt_s;
      end
   end

endmodule

// File: tb/tb_sweep_frame_packer.sv
// Testbench for sweep_frame_packer with READ_SCALAR=4.
// A FIFO model pops blocks on fifo_rd_en and queues the expected frame for
// each popped block. A monitor compares every accepted beat with that queue.
`timescale 1ns/1ps
module tb_sweep_frame_packer;
   localparam int         WIDTH = 8;
   localparam int         RS    = 4;
   localparam int         CW    = 5;
   localparam logic [7:0] HDR   = 8'hA5;

   logic           clk = 1'b0;
   logic           reset;
   logic           enable;
   logic [CW-1:0]  fifo_count;
   logic [31:0]    fifo_dout;
   logic           fifo_rd_en;
   logic           busy;
   logic [15:0]    frame_count;

   sweep_frame_packer_if #(.WIDTH(WIDTH)) sif();

   sweep_frame_packer #(
      .WIDTH(WIDTH), .READ_SCALAR(RS), .COUNT_W(CW), .HEADER(HDR)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .fifo_count(fifo_count), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
      .stream(sif), .busy(busy), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int rd_pulses = 0;
   int extra = 0;
   int model_seq = 0;
   int beat_idx = 0;
   int last_cnt = 0;
   logic [31:0] fifo_q[$];
   logic [8:0]  exp_q[$];
   logic [7:0]  obs_log[$];
   logic [7:0]  seq_log[$];
   int          rd_cycles[$];
   int          hdr_cycles[$];
   int          csum_cycles[$];
   logic        prev_stall = 1'b0;
   logic [7:0]  prev_data;
   logic        prev_last;
   logic [31:0] pop_blk;
   logic [8:0]  exp_beat;

   logic [7:0] basic_exp[7] = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
   logic [7:0] b2b_exp[14]  = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A,
                                8'hA5, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd_count();
      fifo_count = CW'(fifo_q.size() * RS + extra);
   endtask

   task automatic push_blk(input logic [31:0] b);
      fifo_q.push_back(b);
      upd_count();
   endtask

   // Reference frame: header, seq, samples LSB first, then (seq+sum) mod 256.
   function automatic void model_frame(input logic [31:0] blk);
      int sum;
      sum = model_seq;
      exp_q.push_back({1'b0, HDR});
      exp_q.push_back({1'b0, 8'(model_seq)});
      for (int i = 0; i < RS; i++) begin
         sum += int'(blk[8*i +: 8]);
         exp_q.push_back({1'b0, blk[8*i +: 8]});
      end
      exp_q.push_back({1'b1, 8'(sum % 256)});
      model_seq = (model_seq + 1) % 256;
   endfunction

   task automatic clear_model();
      fifo_q.delete(); exp_q.delete(); obs_log.delete(); seq_log.delete();
      rd_cycles.delete(); hdr_cycles.delete(); csum_cycles.delete();
      model_seq = 0; rd_pulses = 0; last_cnt = 0; extra = 0;
      upd_count();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_model();
      tick(); tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic wait_fc(input int target, input int budget, input string name);
      int n = 0;
      while (frame_count != 16'(target) && n < budget) begin tick(); n++; end
      check(name, 32'(frame_count), 32'(target));
   endtask

   task automatic wait_obs(input int target, input int budget, input string name);
      int n = 0;
      while (obs_log.size() < target && n < budget) begin tick(); n++; end
      check(name, 32'(obs_log.size() >= target), 32'd1);
   endtask

   // FIFO model: pop on fifo_rd_en, data valid the following cycle.
   always @(posedge clk) begin
      if (!reset && fifo_rd_en) begin
         rd_pulses++;
         rd_cycles.push_back(cyc);
         if (fifo_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL pop_on_empty: got rd_en=1, expected no pop (t=%0t)", $time);
         end else begin
            pop_blk = fifo_q.pop_front();
            model_frame(pop_blk);
            #1;
            fifo_dout = pop_blk;
            upd_count();
         end
      end
   end

   // Monitor: hold-stable checks under stall and scoreboard compare on handshake.
   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         prev_stall = 1'b0;
         beat_idx = 0;
      end else begin
         if (prev_stall) begin
            check("stall_valid", 32'(sif.m_valid), 32'd1);
            check("stall_data", 32'(sif.m_data), 32'(prev_data));
            check("stall_last", 32'(sif.m_last), 32'(prev_last));
         end
         if (sif.m_valid && sif.m_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL unexpected_beat: got %0h, expected no beat (t=%0t)", sif.m_data, $time);
            end else begin
               exp_beat = exp_q.pop_front();
               check("beat_data", 32'(sif.m_data), 32'(exp_beat[7:0]));
               check("beat_last", 32'(sif.m_last), 32'(exp_beat[8]));
            end
            obs_log.push_back(sif.m_data);
            if (beat_idx == 0) hdr_cycles.push_back(cyc);
            if (beat_idx == 1) seq_log.push_back(sif.m_data);
            if (sif.m_last) begin
               beat_idx = 0;
               last_cnt++;
               csum_cycles.push_back(cyc);
            end else begin
               beat_idx++;
            end
         end
         prev_stall = sif.m_valid && !sif.m_ready;
         prev_data  = sif.m_data;
         prev_last  = sif.m_last;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; enable = 1'b0; sif.m_ready = 1'b0; fifo_dout = 32'd0;
      clear_model();
      tick(); tick();
      check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      check("rst_valid", 32'(sif.m_valid), 32'd0);
      check("rst_last", 32'(sif.m_last), 32'd0);
      check("rst_data", 32'(sif.m_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_fcount", 32'(frame_count), 32'd0);
      reset = 1'b0;
      tick();

      // Basic frame.
      push_blk(32'h04030201);
      enable = 1'b1; sif.m_ready = 1'b1;
      wait_fc(1, 200, "basic_fcount");
      tick(); tick(); tick();
      check("basic_busy", 32'(busy), 32'd0);
      check("basic_rd_pulses", 32'(rd_pulses), 32'd1);
      check("basic_last_cnt", 32'(last_cnt), 32'd1);
      for (int i = 0; i < 7; i++)
         check("basic_beat", 32'((i < obs_log.size()) ? obs_log[i] : 8'hEE), 32'(basic_exp[i]));
      check("basic_latency", 32'((hdr_cycles.size() > 0 && rd_cycles.size() > 0) ?
                                 hdr_cycles[0] - rd_cycles[0] : -1), 32'd2);

      // Backpressure on sample beat 02.
      do_reset();
      push_blk(32'h04030201);
      enable = 1'b1; sif.m_ready = 1'b1;
      n = 0;
      while (!(sif.m_valid && sif.m_data == 8'h02) && n < 200) begin tick(); n++; end
      check("bp_reach", 32'(sif.m_valid && sif.m_data == 8'h02), 32'd1);
      sif.m_ready = 1'b0;
      repeat (5) begin
         tick();
         check("bp_hold_valid", 32'(sif.m_valid), 32'd1);
         check("bp_hold_data", 32'(sif.m_data), 32'h02);
      end
      sif.m_ready = 1'b1;
      wait_fc(1, 200, "bp_fcount");
      tick(); tick(); tick(); tick(); tick();
      for (int i = 0; i < 7; i++)
         check("bp_beat", 32'((i < obs_log.size()) ? obs_log[i] : 8'hEE), 32'(basic_exp[i]));
      check("bp_rd_pulses", 32'(rd_pulses), 32'd1);

      // Back-to-back with checksum overflow.
      do_reset();
      push_blk(32'h04030201);
      push_blk(32'hFFFFFFFF);
      enable = 1'b1; sif.m_ready = 1'b1;
      wait_fc(2, 300, "b2b_fcount");
      tick(); tick();
      for (int i = 0; i < 14; i++)
         check("b2b_beat", 32'((i < obs_log.size()) ? obs_log[i] : 8'hEE), 32'(b2b_exp[i]));
      check("b2b_rd_after_csum", 32'((rd_cycles.size() > 1 && csum_cycles.size() > 0) ?
                                     rd_cycles[1] - csum_cycles[0] : -1), 32'd2);
      check("b2b_gap", 32'((hdr_cycles.size() > 1 && csum_cycles.size() > 0) ?
                           hdr_cycles[1] - csum_cycles[0] : -1), 32'd4);
      check("b2b_drained", 32'(exp_q.size()), 32'd0);

      // Gating: enable low with enough data.
      do_reset();
      enable = 1'b0;
      push_blk(32'h11223344);
      extra = 2; upd_count();
      repeat (100) tick();
      check("gate_en_rd", 32'(rd_pulses), 32'd0);
      check("gate_en_busy", 32'(busy), 32'd0);
      // Gating: enable high with too few samples.
      fifo_q.delete(); extra = 3; upd_count();
      enable = 1'b1;
      repeat (50) tick();
      check("gate_cnt_rd", 32'(rd_pulses), 32'd0);
      // Enable dropped during DATA: frame completes, no further fetch.
      extra = 0;
      push_blk(32'h89ABCDEF);
      push_blk(32'h01020304);
      sif.m_ready = 1'b1;
      wait_obs(3, 200, "drop_reach_data");
      enable = 1'b0;
      wait_fc(1, 200, "drop_fcount");
      repeat (30) tick();
      check("drop_rd", 32'(rd_pulses), 32'd1);
      check("drop_last", 32'(last_cnt), 32'd1);
      check("drop_busy", 32'(busy), 32'd0);
      check("drop_fcount_hold", 32'(frame_count), 32'd1);

      // Randomized run of 257 frames with random backpressure and enable.
      do_reset();
      n = 0;
      begin
         int pushed = 0;
         while (frame_count != 16'd257 && n < 30000) begin
            sif.m_ready = ($urandom_range(0, 3) != 0);
            enable = ($urandom_range(0, 7) != 0);
            if (fifo_q.size() < 3 && pushed < 257) begin
               push_blk($urandom);
               pushed++;
            end
            tick();
            n++;
         end
      end
      sif.m_ready = 1'b1;
      tick(); tick();
      check("wrap_fcount", 32'(frame_count), 32'd257);
      check("wrap_seq_count", 32'(seq_log.size()), 32'd257);
      check("wrap_seq_256", 32'((seq_log.size() > 256) ? seq_log[256] : 8'hEE), 32'h00);
      check("wrap_seq_255", 32'((seq_log.size() > 255) ? seq_log[255] : 8'hEE), 32'hFF);
      check("wrap_drained", 32'(exp_q.size()), 32'd0);

      // Reset mid-frame at DATA index 1.
      do_reset();
      push_blk(32'h44332211);
      enable = 1'b1; sif.m_ready = 1'b1;
      wait_obs(3, 200, "mid_reach_data");
      check("mid_pre_valid", 32'(sif.m_valid), 32'd1);
      check("mid_pre_data", 32'(sif.m_data), 32'h22);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rd_en", 32'(fifo_rd_en), 32'd0);
      check("mid_valid", 32'(sif.m_valid), 32'd0);
      check("mid_last", 32'(sif.m_last), 32'd0);
      check("mid_data", 32'(sif.m_data), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_fcount", 32'(frame_count), 32'd0);
      clear_model();
      tick(); tick();
      reset = 1'b0;
      tick();
      check("post_fcount0", 32'(frame_count), 32'd0);
      push_blk(32'h04030201);
      wait_fc(1, 200, "post_fcount1");
      tick(); tick();
      check("post_seq", 32'((seq_log.size() > 0) ? seq_log[0] : 8'hEE), 32'h00);
      check("post_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
